peripheral_spram_ahb_ws: RTL

//   AHB-Lite slave around a single-port word-organised SRAM, next generation of the spram AHB4 peripheral.

---
 rtl/peripheral_spram_ahb_ws.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/peripheral_spram_ahb_ws.sv
`default_nettype none
// ============================================================================
//  Module  : peripheral_spram_ahb_ws
//  Purpose : AHB-Lite slave in front of a single-port, word-organised SRAM.
//            Programmable read wait states, byte/halfword lane writes,
//            ERROR responses for bad size / misalignment / out-of-range
//            addresses, and write-to-read forwarding for back-to-back access.
//  Ports   : HCLK, HRESETn (async, active low)
//            HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY  - address phase
//            HBURST, HPROT, HMASTLOCK                    - ignored
//            HWDATA                                      - write data phase
//            HRDATA, HREADYOUT, HRESP                    - registered response
//  Revision: 1.0  initial release
// ============================================================================
module peripheral_spram_ahb_ws #(
   parameter int MEM_DEPTH    = 256,
   parameter int PLEN         = 10,
   parameter int XLEN         = 32,
   parameter int WAIT_STATES  = 0,
   parameter int ERROR_ON_OOR = 1
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            HSEL,
   input  logic [PLEN-1:0] HADDR,
   input  logic [XLEN-1:0] HWDATA,
   output logic [XLEN-1:0] HRDATA,
   input  logic            HWRITE,
   input  logic [2:0]      HSIZE,
   input  logic [2:0]      HBURST,
   input  logic [3:0]      HPROT,
   input  logic [1:0]      HTRANS,
   input  logic            HMASTLOCK,
   input  logic            HREADY,
   output logic            HREADYOUT,
   output logic            HRESP
);

   localparam int c_NB = XLEN / 8;
   localparam int c_BS = $clog2(c_NB);
   localparam int c_IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_WAIT = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_ERR1    = 3'd4,
      ST_ERR2    = 3'd5
   } state_t;

   state_t            r_state;
   logic [2:0]        r_cnt;
   logic [c_IW-1:0]   r_rd_idx;
   logic [c_IW-1:0]   r_wr_idx;
   logic [c_NB-1:0]   r_wr_mask;
   logic              r_pend_valid;
   logic [c_IW-1:0]   r_pend_idx;
   logic [XLEN-1:0]   r_pend_data;
   logic [XLEN-1:0]   r_pend_bm;
   logic [XLEN-1:0]   r_mem [MEM_DEPTH];

   logic [c_BS-1:0]   w_off;
   logic [c_BS-1:0]   w_amask;
   logic [PLEN-1:0]   w_word;
   logic [c_IW-1:0]   w_midx;
   logic [c_IW-1:0]   w_ridx;
   logic [c_NB-1:0]   w_lanes;
   logic [XLEN-1:0]   w_wr_bm;
   logic [XLEN-1:0]   w_fwd;
   logic              w_accept;
   logic              w_err;
   logic              w_unused;

   assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   // Address decode of the current address phase
   assign w_accept = HSEL && HREADY && HTRANS[1];
   assign w_off    = HADDR[c_BS-1:0];
   assign w_amask  = c_BS'((32'd1 << HSIZE) - 32'd1);
   assign w_word   = HADDR >> c_BS;
   // Index is reduced modulo depth; when range errors are enabled, any
   // out-of-range index is rejected before it can be used.
   assign w_midx   = c_IW'(32'(w_word) % 32'(MEM_DEPTH));
   assign w_err    = (HSIZE > 3'(c_BS)) || ((w_off & w_amask) != '0) ||
                     ((ERROR_ON_OOR != 0) && (32'(w_word) >= 32'(MEM_DEPTH)));

   always_comb begin
      w_lanes = '0;
      for (int b = 0; b < c_NB; b++) begin
         if ((b >= int'(w_off)) && (b < int'(w_off) + (1 << HSIZE)))
            w_lanes[b] = 1'b1;
      end
   end

   always_comb begin
      w_wr_bm = '0;
      for (int b = 0; b < c_NB; b++)
         w_wr_bm[8*b +: 8] = {8{r_wr_mask[b]}};
   end

   // Read word with forwarding: the array value is overlaid first by the
   // committing (older) write, then by the write in its data phase (newer).
   assign w_ridx = (r_state == ST_RD_WAIT) ? r_rd_idx : w_midx;

   always_comb begin
      w_fwd = r_mem[w_ridx];
      if (r_pend_valid && (r_pend_idx == w_ridx))
         w_fwd = (w_fwd & ~r_pend_bm) | r_pend_data;
      if ((r_state == ST_WR_DATA) && (r_wr_idx == w_ridx))
         w_fwd = (w_fwd & ~w_wr_bm) | (HWDATA & w_wr_bm);
   end

   // Array: single write port driven only by the committing pending write
   always_ff @(posedge HCLK) begin
      if (r_pend_valid)
         r_mem[r_pend_idx] <= (r_mem[r_pend_idx] & ~r_pend_bm) | r_pend_data;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state      <= ST_IDLE;
         HREADYOUT    <= 1'b1;
         HRESP        <= 1'b0;
         HRDATA       <= '0;
         r_cnt        <= '0;
         r_rd_idx     <= '0;
         r_wr_idx     <= '0;
         r_wr_mask    <= '0;
         r_pend_valid <= 1'b0;
         r_pend_idx   <= '0;
         r_pend_data  <= '0;
         r_pend_bm    <= '0;
      end else begin
         // Write data is only known in WR_DATA; park it for one cycle and
         // commit it on the following edge.
         if (r_state == ST_WR_DATA) begin
            r_pend_valid <= 1'b1;
            r_pend_idx   <= r_wr_idx;
            r_pend_data  <= HWDATA & w_wr_bm;
            r_pend_bm    <= w_wr_bm;
         end else begin
            r_pend_valid <= 1'b0;
         end

         case (r_state)
            ST_RD_WAIT: begin
               if (r_cnt == 3'd1) begin
                  r_state   <= ST_RD_DATA;
                  HREADYOUT <= 1'b1;
                  HRDATA    <= w_fwd;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            ST_ERR1: begin
               r_state   <= ST_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end
            default: begin
               if (w_accept) begin
                  if (w_err) begin
                     r_state   <= ST_ERR1;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b1;
                  end else if (HWRITE) begin
                     r_state   <= ST_WR_DATA;
                     HREADYOUT <= 1'b1;
                     HRESP     <= 1'b0;
                     r_wr_idx  <= w_midx;
                     r_wr_mask <= w_lanes;
                  end else if (WAIT_STATES == 0) begin
                     r_state   <= ST_RD_DATA;
                     HREADYOUT <= 1'b1;
                     HRESP     <= 1'b0;
                     HRDATA    <= w_fwd;
                  end else begin
                     r_state   <= ST_RD_WAIT;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b0;
                     r_cnt     <= 3'(WAIT_STATES);
                     r_rd_idx  <= w_midx;
                  end
               end else begin
                  r_state   <= ST_IDLE;
                  HREADYOUT <= 1'b1;
                  HRESP     <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire
